// File: rtl/dds_cfg_pkg.sv
// Shared constants and FSM state type for the DDS configuration scheduler.
package dds_cfg_pkg;

    localparam int DIN_WIDTH_DEF = 32;
    localparam int NUM_CH_DEF    = 4;
    localparam int CH_BITS_DEF   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward with wrap.
module rr_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2
) (
    input  logic [NUM_CH-1:0]  req,
    input  logic [CH_BITS-1:0] last_grant,
    output logic [CH_BITS-1:0] grant,
    output logic               any_req
);

    always_comb begin
        int                 idx_int;
        logic [CH_BITS-1:0] idx;
        grant   = '0;
        any_req = 1'b0;
        idx_int = 0;
        idx     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx_int = (int'(last_grant) + k) % NUM_CH;
            idx     = CH_BITS'(idx_int);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = idx;
            end
        end
    end

endmodule

// File: rtl/dds_config_scheduler.sv
// Tracks per-channel config words and serialises owed updates onto one
// shared AXI-Stream DDS config port using round-robin arbitration.
module dds_config_scheduler
    import dds_cfg_pkg::*;
#(
    parameter int DIN_WIDTH = DIN_WIDTH_DEF,
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int CH_BITS   = CH_BITS_DEF
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [NUM_CH*DIN_WIDTH-1:0] data_in,
    input  logic                        m_axis_tready,
    output logic [DIN_WIDTH-1:0]        m_axis_tdata,
    output logic [CH_BITS-1:0]          m_axis_tuser,
    output logic                        m_axis_tvalid,
    output logic [NUM_CH-1:0]           pending
);

    state_t                 state_q, state_d;
    logic [DIN_WIDTH-1:0]   in_reg_q   [NUM_CH];
    logic [DIN_WIDTH-1:0]   sent_reg_q [NUM_CH];
    logic [DIN_WIDTH-1:0]   sent_reg_d [NUM_CH];
    logic [NUM_CH-1:0]      force_q, force_d;
    logic [CH_BITS-1:0]     last_grant_q, last_grant_d;
    logic [DIN_WIDTH-1:0]   tdata_q, tdata_d;
    logic [CH_BITS-1:0]     tuser_q, tuser_d;
    // Blocks arbitration on the first cycle out of reset, while in_reg still
    // holds the reset zeros instead of the live bus values.
    logic                   init_q;
    logic [CH_BITS-1:0]     grant;
    logic                   any_req;

    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pending[i] = (in_reg_q[i] != sent_reg_q[i]) || force_q[i];
        end
    end

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_arb (
        .req        (pending),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any_req    (any_req)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tdata_d      = tdata_q;
        tuser_d      = tuser_q;
        force_d      = force_q;
        sent_reg_d   = sent_reg_q;
        case (state_q)
            IDLE: begin
                if (!init_q && any_req) begin
                    state_d           = SEND;
                    last_grant_d      = grant;
                    tdata_d           = in_reg_q[grant];
                    tuser_d           = grant;
                    sent_reg_d[grant] = in_reg_q[grant];
                    force_d[grant]    = 1'b0;
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            force_q      <= '1;
            last_grant_q <= CH_BITS'(NUM_CH - 1);
            tdata_q      <= '0;
            tuser_q      <= '0;
            init_q       <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                in_reg_q[i]   <= '0;
                sent_reg_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            force_q      <= force_d;
            last_grant_q <= last_grant_d;
            tdata_q      <= tdata_d;
            tuser_q      <= tuser_d;
            init_q       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                in_reg_q[i]   <= data_in[i*DIN_WIDTH +: DIN_WIDTH];
                sent_reg_q[i] <= sent_reg_d[i];
            end
        end
    end

    assign m_axis_tvalid = (state_q == SEND);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_dds_config_scheduler.sv
// Directed self-checking bench for dds_config_scheduler (4 channels x 32 bits).
module tb_dds_config_scheduler;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int CB  = 2;

    logic              aclk;
    logic              areset;
    logic [NCH*DW-1:0] data_in;
    logic              m_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [CB-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic [NCH-1:0]    pending;

    int checks;
    int failures;
    logic [DW-1:0] chv [NCH];

    dds_config_scheduler #(
        .DIN_WIDTH (DW),
        .NUM_CH    (NCH),
        .CH_BITS   (CB)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .data_in       (data_in),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .pending       (pending)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] v);
        chv[ch] = v;
        data_in[ch*DW +: DW] = v;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int ch, input logic [DW-1:0] d);
        check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd1);
        check({tag, "_tuser"},  64'(m_axis_tuser),  64'(ch));
        check({tag, "_tdata"},  64'(m_axis_tdata),  64'(d));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tvalid0"}, 64'(m_axis_tvalid), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        data_in  = '0;
        areset   = 1'b1;
        m_axis_tready = 1'b1;
        set_ch(0, 32'h1);
        set_ch(1, 32'h2);
        set_ch(2, 32'h3);
        set_ch(3, 32'h4);
        tick();
        tick();

        // Reset state
        check("rst_tvalid",  64'(m_axis_tvalid), 64'd0);
        check("rst_tdata",   64'(m_axis_tdata),  64'd0);
        check("rst_tuser",   64'(m_axis_tuser),  64'd0);
        check("rst_pending", 64'(pending),       64'hF);

        // Forced initial sequence 0..3 after release, beats 2 cycles apart
        areset = 1'b0;
        tick();
        check_idle("init_first");
        for (int c = 0; c < NCH; c++) begin
            tick();
            check_beat("init_beat", c, chv[c]);
            tick();
            check_idle("init_gap");
        end
        check("init_pending", 64'(pending), 64'h0);

        // Single change on ch2: one beat one cycle after capture
        set_ch(2, 32'hDEADBEEF);
        tick();
        check_idle("ch2_e0");
        check("ch2_pend", 64'(pending), 64'h4);
        tick();
        check_beat("ch2_beat", 2, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("ch2_after");
        end
        check("ch2_pend0", 64'(pending), 64'h0);

        // Make last_grant = 1, then ch1 and ch3 change together
        set_ch(1, 32'h22);
        tick();
        tick();
        check_beat("lg1_beat", 1, 32'h22);
        tick();
        set_ch(1, 32'h55);
        set_ch(3, 32'h77);
        tick();
        check("rr_pend", 64'(pending), 64'hA);
        tick();
        check_beat("rr_first", 3, 32'h77);
        tick();
        check_idle("rr_gap");
        tick();
        check_beat("rr_second", 1, 32'h55);
        tick();
        check_idle("rr_end");
        check("rr_pend0", 64'(pending), 64'h0);

        // Stall with tready low; ch0 updates coalesce, ch3 bounces back
        set_ch(0, 32'h10);
        tick();
        m_axis_tready = 1'b0;
        tick();
        check_beat("stall_start", 0, 32'h10);
        for (int k = 0; k < 10; k++) begin
            if (k == 2) set_ch(0, 32'h20);
            if (k == 4) set_ch(3, 32'h78);
            if (k == 5) set_ch(0, 32'h30);
            if (k == 6) set_ch(3, 32'h77);
            tick();
            check_beat("stall_hold", 0, 32'h10);
        end
        check("stall_pend", 64'(pending), 64'h1);
        m_axis_tready = 1'b1;
        tick();
        check_idle("stall_hs");
        tick();
        check_beat("stall_coalesced", 0, 32'h30);
        tick();
        check_idle("stall_gap");
        tick();
        check_idle("stall_single");
        check("stall_pend0", 64'(pending), 64'h0);

        // ch2 changes during its own in-flight beat
        set_ch(2, 32'h5);
        tick();
        m_axis_tready = 1'b0;
        tick();
        check_beat("inflight_a", 2, 32'h5);
        set_ch(2, 32'h6);
        tick();
        check_beat("inflight_hold", 2, 32'h5);
        check("inflight_pend", 64'(pending), 64'h4);
        m_axis_tready = 1'b1;
        tick();
        check_idle("inflight_hs");
        tick();
        check_beat("inflight_b", 2, 32'h6);
        tick();
        check_idle("inflight_end");
        check("inflight_pend0", 64'(pending), 64'h0);

        // Reset mid-SEND aborts the beat, forced sequence restarts
        set_ch(1, 32'h99);
        tick();
        m_axis_tready = 1'b0;
        tick();
        check_beat("abort_pre", 1, 32'h99);
        areset = 1'b1;
        tick();
        check("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("abort_tdata",  64'(m_axis_tdata),  64'd0);
        check("abort_pend",   64'(pending),       64'hF);
        areset = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        check_idle("restart_first");
        for (int c = 0; c < NCH; c++) begin
            tick();
            check_beat("restart_beat", c, chv[c]);
            tick();
            check_idle("restart_gap");
        end
        check("restart_pend0", 64'(pending), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_config_scheduler.md
DDS_CONFIG_SCHEDULER -- requirements
Module: dds_config_scheduler

Interface
REQ-001 Parameter DIN_WIDTH, default 32: width of each channel's config word.
REQ-002 Parameter NUM_CH, default 4: number of requesting channels (2..8).
REQ-003 Parameter CH_BITS, default 2: channel index width, equal to clog2(NUM_CH).
REQ-004 aclk  input  1  single clock; all logic on its rising edge.
REQ-005 areset  input  1  reset, synchronous, active-high.
REQ-006 data_in  input  NUM_CH*DIN_WIDTH  parallel config buses; channel i at bits [i*DIN_WIDTH +: DIN_WIDTH].
REQ-007 m_axis_tready  input  1  shared DDS config port ready.
REQ-008 m_axis_tdata  output  DIN_WIDTH  config word being sent.
REQ-009 m_axis_tuser  output  CH_BITS  channel index of m_axis_tdata.
REQ-010 m_axis_tvalid  output  1  beat valid.
REQ-011 pending  output  NUM_CH  per-channel "update owed" status.

Function
REQ-012 Block SHALL register data_in every cycle into in_reg[i], and SHALL hold sent_reg[i], the last word issued per channel.
REQ-013 pending[i] SHALL be (in_reg[i] != sent_reg[i]) OR force[i], combinational from registers.
REQ-014 FSM SHALL have two states: IDLE (tvalid=0) and SEND (tvalid=1).
REQ-015 IDLE with any pending bit: SHALL grant one channel g by round-robin, load tdata<=in_reg[g], tuser<=g, sent_reg[g]<=in_reg[g], clear force[g], go SEND.
REQ-016 Round-robin SHALL search from (last_grant+1) mod NUM_CH upward with wrap; last_grant updates on each grant.
REQ-017 IDLE with no pending bit: SHALL remain IDLE.
REQ-018 SEND: tdata, tuser, tvalid SHALL stay stable until tready=1; on tvalid&tready edge SHALL go IDLE.
REQ-019 Beats SHALL be separated by at least one IDLE cycle; peak rate one beat per 2 cycles.
REQ-020 Latency: data_in change sampled at edge E0 SHALL yield tvalid=1 after edge E1 when FSM was IDLE and channel wins arbitration.
REQ-021 Several changes of a channel before its grant SHALL produce one beat carrying the in_reg value at grant time.
REQ-022 A change of channel g while its beat is in SEND SHALL not alter the in-flight beat and SHALL re-assert pending[g] for a later beat.
REQ-023 A channel returning to sent_reg value before grant SHALL clear pending and issue no beat.
REQ-024 tready held low SHALL stall indefinitely with no loss of pending updates on any channel.

Reset
REQ-025 While areset=1 at an edge: tvalid=0, tdata=0, tuser=0, in_reg=0, sent_reg=0, force=all ones, last_grant=NUM_CH-1, state=IDLE.
REQ-026 Reset asserted mid-SEND SHALL abort the beat (tvalid=0 next cycle); no handshake completes that cycle.
REQ-027 After reset release every channel SHALL be sent once (forced), in order 0..NUM_CH-1 when tready=1, so the DDS gets initial values.

Structure
REQ-028 Shared package dds_cfg_pkg SHALL hold default DIN_WIDTH/NUM_CH/CH_BITS constants and the state enum (IDLE, SEND).
REQ-029 Round-robin priority logic SHALL be a sub-module rr_arbiter (inputs req[NUM_CH], last_grant; outputs grant index, any_req), purely combinational.

Verification
REQ-030 Reset release, data_in ch0..3 = 0x1,0x2,0x3,0x4, tready=1 -> four beats tuser 0,1,2,3 with tdata 0x1..0x4, each 2 cycles apart, then pending=0.
REQ-031 Idle, ch2 changes to 0xDEADBEEF at E0 -> tvalid=1 after E1, tuser=2, tdata=0xDEADBEEF; single beat only.
REQ-032 ch1 and ch3 change same cycle, last_grant=1 -> ch3 beat first, then ch1.
REQ-033 tready=0 for 10 cycles in SEND while ch0 changes 0x10->0x20->0x30 -> outputs stable throughout; after handshake, one ch0 beat with 0x30.
REQ-034 ch2 changes 0x5->0x6 during its own SEND of 0x5 -> 0x5 beat completes unchanged, followed by one ch2 beat with 0x6.
REQ-035 areset pulsed mid-SEND -> tvalid=0 next cycle, then forced sequence 0..3 restarts.
